scoreboard_scan: RTL and testbench

Parametrised multi-digit scoreboard for the lab board. Each push button steps one digit up or down (direction per switch) through a debounced, edge-detected input path. Digit values are held in registers, optionally chained with carry, and shown on the common-anode 7-segment display by a time-multiplexed scanner. It is the next generation of the fixed 4-digit scoreboard and sits directly between the board buttons/switches and the display pins.

---
 rtl/scoreboard_pkg.sv | 65 ++++++
 rtl/scoreboard_debounce.sv | 56 +++++
 rtl/scoreboard_scan.sv | 177 +++++++++++++++++
 tb/tb_scoreboard_scan.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/scoreboard_pkg.sv
// scoreboard_pkg: shared constants and helpers for the scanned scoreboard.
// Holds the common-anode 7-segment glyphs ({dp,g,f,e,d,c,b,a}, active-low),
// the blank pattern, the digit width and the single-digit up/down step.
package scoreboard_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Glyphs carry dp = 1 (off); the wrap flag clears bit 7 when it is lit.
    localparam logic [7:0] GLYPH_0 = 8'hC0;
    localparam logic [7:0] GLYPH_1 = 8'hF9;
    localparam logic [7:0] GLYPH_2 = 8'hA4;
    localparam logic [7:0] GLYPH_3 = 8'hB0;
    localparam logic [7:0] GLYPH_4 = 8'h99;
    localparam logic [7:0] GLYPH_5 = 8'h92;
    localparam logic [7:0] GLYPH_6 = 8'h82;
    localparam logic [7:0] GLYPH_7 = 8'hF8;
    localparam logic [7:0] GLYPH_8 = 8'h80;
    localparam logic [7:0] GLYPH_9 = 8'h90;
    localparam logic [7:0] GLYPH_A = 8'h88;
    localparam logic [7:0] GLYPH_B = 8'h83;
    localparam logic [7:0] GLYPH_C = 8'hC6;
    localparam logic [7:0] GLYPH_D = 8'hA1;
    localparam logic [7:0] GLYPH_E = 8'h86;
    localparam logic [7:0] GLYPH_F = 8'h8E;

    // Hex digit to segment pattern.
    function automatic logic [7:0] glyph(input logic [DIGIT_W-1:0] v);
        logic [7:0] g;
        case (v)
            4'h0:    g = GLYPH_0;
            4'h1:    g = GLYPH_1;
            4'h2:    g = GLYPH_2;
            4'h3:    g = GLYPH_3;
            4'h4:    g = GLYPH_4;
            4'h5:    g = GLYPH_5;
            4'h6:    g = GLYPH_6;
            4'h7:    g = GLYPH_7;
            4'h8:    g = GLYPH_8;
            4'h9:    g = GLYPH_9;
            4'hA:    g = GLYPH_A;
            4'hB:    g = GLYPH_B;
            4'hC:    g = GLYPH_C;
            4'hD:    g = GLYPH_D;
            4'hE:    g = GLYPH_E;
            default: g = GLYPH_F;
        endcase
        return g;
    endfunction

    // One step of a digit in [0, vmax]; returns {wrapped, new_value}.
    function automatic logic [DIGIT_W:0] digit_step(input logic [DIGIT_W-1:0] v,
                                                    input logic               dec,
                                                    input logic [DIGIT_W-1:0] vmax);
        logic [DIGIT_W:0] r;
        if (dec) begin
            r = (v == '0) ? {1'b1, vmax} : {1'b0, v - 4'd1};
        end else begin
            r = (v == vmax) ? {1'b1, 4'd0} : {1'b0, v + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/scoreboard_debounce.sv
// scoreboard_debounce: one button channel.
// Two-flop synchronizer, then a debounced level that only follows the
// synchronized input after DEBOUNCE_CYCLES consecutive differing samples
// (any agreeing sample restarts the count). pulse is high for the one cycle
// in which the debounced level first reads 1 after a rising change.
module scoreboard_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta;
    logic             sync;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // Bring the raw button into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
        end
    end

    // Count consecutive disagreeing samples; flip the level and emit the
    // rising pulse on the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
            pulse <= 1'b0;
        end else if (sync != level) begin
            if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync;
                pulse <= sync;
            end else begin
                cnt   <= cnt + CNT_W'(1);
                pulse <= 1'b0;
            end
        end else begin
            cnt   <= '0;
            pulse <= 1'b0;
        end
    end

endmodule

// File: rtl/scoreboard_scan.sv
// scoreboard_scan: multi-digit up/down scoreboard with a scanned
// common-anode 7-segment display.
// Buttons pass through scoreboard_debounce, set a pending bit (direction
// captured from sw), and the pending bits update the digit registers.
// Build option SCOREBOARD_CARRY_EN: digits form one number (digit 0 least
// significant), one pending request is serviced per cycle, lowest index
// first, with carry/borrow into the higher digits. Without it every digit
// is independent and all pending requests are applied together.
module scoreboard_scan
    import scoreboard_pkg::*;
#(
    parameter int          DIGITS          = 4,
    parameter int          BCD             = 0,
    parameter int unsigned DEBOUNCE_CYCLES = 20'd500000,
    parameter int          SCAN_DIV        = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIGITS-1:0] btn,
    input  logic [DIGITS-1:0] sw,
    output logic [DIGITS-1:0] AN,
    output logic [7:0]        SEGMENT,
    output logic              BTNX4
);

    localparam logic [DIGIT_W-1:0] DMAX = (BCD != 0) ? 4'd9 : 4'd15;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

    logic [DIGITS-1:0]              pulse;
    logic [DIGITS-1:0]              pend;
    logic [DIGITS-1:0]              pdir;
    logic [DIGITS-1:0]              pend_clr;
    logic [DIGITS-1:0]              wf;
    logic [DIGITS-1:0]              wf_set;
    logic [DIGITS-1:0][DIGIT_W-1:0] digit_q;
    logic [DIGITS-1:0][DIGIT_W-1:0] digit_d;

    logic [PRE_W-1:0]  pre;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_new;
    logic              scan_on;
    logic [DIGITS-1:0] an_new;
    logic [7:0]        seg_new;

    assign BTNX4 = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_btn
            scoreboard_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_deb (
                .clk  (clk),
                .rst_n(rst_n),
                .din  (btn[gi]),
                .pulse(pulse[gi])
            );
        end
    endgenerate

    // Pending requests: a pulse on a clear bit latches it with its direction;
    // a pulse on an already-set bit is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
            pdir <= '0;
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                if (pend_clr[i]) begin
                    pend[i] <= 1'b0;
                end else if (pulse[i] && !pend[i]) begin
                    pend[i] <= 1'b1;
                    pdir[i] <= sw[i];
                end
            end
        end
    end

`ifdef SCOREBOARD_CARRY_EN
    // Service the lowest pending digit and ripple any wrap upward; the
    // wrap out of the top digit only marks its flag.
    always_comb begin : update_carry
        logic             found;
        logic             run;
        logic             dec;
        logic [DIGIT_W:0] step;
        found    = 1'b0;
        run      = 1'b0;
        dec      = 1'b0;
        step     = '0;
        digit_d  = digit_q;
        wf_set   = '0;
        pend_clr = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!found && pend[i]) begin
                found       = 1'b1;
                run         = 1'b1;
                dec         = pdir[i];
                pend_clr[i] = 1'b1;
            end
            if (run) begin
                step       = digit_step(digit_q[i], dec, DMAX);
                digit_d[i] = step[DIGIT_W-1:0];
                wf_set[i]  = step[DIGIT_W];
                run        = step[DIGIT_W];
            end
        end
    end
`else
    // Apply every pending request to its own digit in the same cycle.
    always_comb begin : update_indep
        logic [DIGIT_W:0] step;
        step     = '0;
        digit_d  = digit_q;
        wf_set   = '0;
        pend_clr = pend;
        for (int i = 0; i < DIGITS; i++) begin
            if (pend[i]) begin
                step       = digit_step(digit_q[i], pdir[i], DMAX);
                digit_d[i] = step[DIGIT_W-1:0];
                wf_set[i]  = step[DIGIT_W];
            end
        end
    end
`endif

    // Digit values and sticky wrap flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q <= '0;
            wf      <= '0;
        end else begin
            digit_q <= digit_d;
            wf      <= wf | wf_set;
        end
    end

    // Next scan slot: the first slot after reset shows digit 0, later slots
    // advance round-robin. Segments come from the live digit value.
    always_comb begin
        logic [7:0] g;
        if (!scan_on) begin
            idx_new = idx;
        end else if (idx == IDX_LAST) begin
            idx_new = '0;
        end else begin
            idx_new = idx + IDX_W'(1);
        end
        an_new          = '1;
        an_new[idx_new] = 1'b0;
        g               = glyph(digit_q[idx_new]);
        seg_new         = g & {~wf[idx_new], 7'h7F};
    end

    // Prescaler and registered display outputs, refreshed on each wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre     <= '0;
            idx     <= '0;
            scan_on <= 1'b0;
            AN      <= '1;
            SEGMENT <= SEG_BLANK;
        end else if (pre == PRE_LAST) begin
            pre     <= '0;
            idx     <= idx_new;
            scan_on <= 1'b1;
            AN      <= an_new;
            SEGMENT <= seg_new;
        end else begin
            pre <= pre + PRE_W'(1);
        end
    end

endmodule

// File: tb/tb_scoreboard_scan.sv
// tb_scoreboard_scan: directed bench for scoreboard_scan with DIGITS=4,
// DEBOUNCE_CYCLES=4, SCAN_DIV=8. A hex instance (BCD=0) carries most of the
// checks; a decimal instance (BCD=1) covers the 9 -> 0 wrap.
// Expectations follow SCOREBOARD_CARRY_EN when the bench is built with it.
module tb_scoreboard_scan;

    logic       clk;
    logic       rst_n;
    logic [3:0] btn;
    logic [3:0] sw;
    logic [3:0] an;
    logic [7:0] seg;
    logic       btnx4;
    logic [3:0] btn_b;
    logic [3:0] sw_b;
    logic [3:0] an_b;
    logic [7:0] seg_b;
    logic       btnx4_b;

    int checks;
    int failures;

    scoreboard_scan #(
        .DIGITS(4), .BCD(0), .DEBOUNCE_CYCLES(4), .SCAN_DIV(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn(btn), .sw(sw),
        .AN(an), .SEGMENT(seg), .BTNX4(btnx4)
    );

    scoreboard_scan #(
        .DIGITS(4), .BCD(1), .DEBOUNCE_CYCLES(4), .SCAN_DIV(8)
    ) dut_bcd (
        .clk(clk), .rst_n(rst_n), .btn(btn_b), .sw(sw_b),
        .AN(an_b), .SEGMENT(seg_b), .BTNX4(btnx4_b)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hold a press long enough to be accepted, then release and let the
    // release settle. which=1 drives the decimal instance.
    task automatic press(input logic [3:0] m, input logic [3:0] d, input bit which);
        if (which) begin
            sw_b = d; btn_b = m;
        end else begin
            sw = d; btn = m;
        end
        repeat (8) tick();
        if (which) btn_b = '0;
        else btn = '0;
        repeat (8) tick();
    endtask

    // Bounded wait for a given anode pattern; an expired bound is a failure.
    task automatic wait_an(input bit which, input logic [3:0] target);
        for (int i = 0; i < 40; i++) begin
            if ((which ? an_b : an) == target) break;
            tick();
        end
        check("an_slot", {28'd0, (which ? an_b : an)}, {28'd0, target});
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; btn = '0; sw = '0; btn_b = '0; sw_b = '0;
        repeat (3) tick();

        // Reset state
        check("rst_an", {28'd0, an}, 32'hF);
        check("rst_seg", {24'd0, seg}, 32'hFF);
        check("rst_btnx4", {31'd0, btnx4}, 32'h0);
        check("rst_digits", {16'd0, dut.digit_q}, 32'h0);

        // First slot appears SCAN_DIV cycles after release
        rst_n = 1'b1;
        repeat (7) tick();
        check("first_slot_early", {28'd0, an}, 32'hF);
        tick();
        check("first_slot_an", {28'd0, an}, 32'hE);
        check("first_slot_seg", {24'd0, seg}, 32'hC0);

        // Scan order E, D, B, 7, E every 8 cycles
        repeat (8) tick(); check("scan_d", {28'd0, an}, 32'hD);
        repeat (8) tick(); check("scan_b", {28'd0, an}, 32'hB);
        repeat (8) tick(); check("scan_7", {28'd0, an}, 32'h7);
        repeat (8) tick(); check("scan_e", {28'd0, an}, 32'hE);

        // Reset mid-scan blanks immediately, then restarts
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_an", {28'd0, an}, 32'hF);
        check("midrst_seg", {24'd0, seg}, 32'hFF);
        tick(); tick();
        rst_n = 1'b1;
        repeat (8) tick();
        check("rerst_an", {28'd0, an}, 32'hE);
        check("rerst_seg", {24'd0, seg}, 32'hC0);

        // Bounces shorter than the debounce window do nothing
        btn = 4'b0001; repeat (3) tick();
        btn = 4'b0000; repeat (2) tick();
        btn = 4'b0001; repeat (2) tick();
        btn = 4'b0000; repeat (12) tick();
        check("bounce", {16'd0, dut.digit_q}, 32'h0);

        // Clean press: debounced edge after 6 cycles, digit 2 cycles later
        sw = '0; btn = 4'b0001;
        repeat (7) tick();
        check("press_early", {16'd0, dut.digit_q}, 32'h0000);
        tick();
        check("press_digit", {16'd0, dut.digit_q}, 32'h0001);
        btn = '0;
        repeat (10) tick();
        check("release", {16'd0, dut.digit_q}, 32'h0001);

        // Decrement wrap on digit 1
        press(4'b0010, 4'b0010, 1'b0);
`ifdef SCOREBOARD_CARRY_EN
        check("dec_digits", {16'd0, dut.digit_q}, 32'hFFF1);
        check("dec_wf", {28'd0, dut.wf}, 32'hE);
`else
        check("dec_digits", {16'd0, dut.digit_q}, 32'h00F1);
        check("dec_wf", {28'd0, dut.wf}, 32'h2);
`endif
        wait_an(1'b0, 4'hD);
        check("dec_seg_dp", {24'd0, seg}, 32'h0E);
        wait_an(1'b0, 4'hE);
        check("dig0_seg", {24'd0, seg}, 32'hF9);

        // Simultaneous presses
        sw = '0;
`ifdef SCOREBOARD_CARRY_EN
        btn = 4'b0101;
        repeat (7) tick();
        check("simul_early", {16'd0, dut.digit_q}, 32'hFFF1);
        tick();
        check("simul_first", {16'd0, dut.digit_q}, 32'hFFF2);
        tick();
        check("simul_second", {16'd0, dut.digit_q}, 32'h00F2);
        check("simul_wf", {28'd0, dut.wf}, 32'hE);
        btn = '0;
        repeat (8) tick();

        // Carry out of digit 0 after preloading F
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        for (int i = 0; i < 15; i++) press(4'b0001, 4'b0000, 1'b0);
        check("preload", {16'd0, dut.digit_q}, 32'h000F);
        check("preload_wf", {28'd0, dut.wf}, 32'h0);
        press(4'b0001, 4'b0000, 1'b0);
        check("carry_digits", {16'd0, dut.digit_q}, 32'h0010);
        check("carry_wf", {28'd0, dut.wf}, 32'h1);
`else
        btn = 4'b1001;
        repeat (7) tick();
        check("simul_early", {16'd0, dut.digit_q}, 32'h00F1);
        tick();
        check("simul_both", {16'd0, dut.digit_q}, 32'h10F2);
        btn = '0;
        repeat (8) tick();
        check("simul_hold", {16'd0, dut.digit_q}, 32'h10F2);
`endif

        // Decimal instance: ten increments wrap digit 0 back to 0
        for (int i = 0; i < 9; i++) press(4'b0001, 4'b0000, 1'b1);
        check("bcd_nine", {16'd0, dut_bcd.digit_q}, 32'h0009);
        check("bcd_nine_wf", {28'd0, dut_bcd.wf}, 32'h0);
        press(4'b0001, 4'b0000, 1'b1);
`ifdef SCOREBOARD_CARRY_EN
        check("bcd_wrap", {16'd0, dut_bcd.digit_q}, 32'h0010);
`else
        check("bcd_wrap", {16'd0, dut_bcd.digit_q}, 32'h0000);
`endif
        check("bcd_wrap_wf", {28'd0, dut_bcd.wf}, 32'h1);
        wait_an(1'b1, 4'hE);
        check("bcd_seg", {24'd0, seg_b}, 32'h40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
